// File: rtl/next_lsu_pkg.sv
// Shared types and helpers for the next_lsu load/store unit.
// Optional feature macro: NEXT_LSU_MISALIGN_TRAP_EN (see next_lsu.sv).
package next_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    function automatic logic funct3_valid(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_H, LSU_HU: return off[0];
            LSU_W:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_H, LSU_HU: return {off[1], 1'b0};
            LSU_W:         return 2'b00;
            default:       return off;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_B, LSU_BU: return 4'b0001 << off;
            LSU_H, LSU_HU: return off[1] ? 4'b1100 : 4'b0011;
            default:       return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_repl(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            LSU_B, LSU_BU: return {4{wdata[7:0]}};
            LSU_H, LSU_HU: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/next_load_extract.sv
// Combinational load-data lane select and sign/zero extension.
module next_load_extract
    import next_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            LSU_B:   result = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  result = {24'b0, byte_sel};
            LSU_H:   result = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  result = {16'b0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/next_lsu.sv
// Load/store unit: core access -> byte-lane bus request/grant/rvalid transaction.
// Define NEXT_LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning down.
module next_lsu
    import next_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    lsu_state_e        state, state_n;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_result;
    logic              accept;
    logic              acc_err;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr;
    assign accept = req_valid && (state == IDLE);

`ifdef NEXT_LSU_MISALIGN_TRAP_EN
    assign acc_err = !funct3_valid(req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
    assign acc_err = !funct3_valid(req_funct3);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = acc_err ? DONE : REQ;
            REQ:     if (bus_gnt) state_n = we_q ? DONE : WAIT;
            WAIT:    if (bus_rvalid) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Misaligned offsets are aligned down at capture so lanes and extraction agree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= {req_addr[ADDR_W-1:2], align_off(req_funct3, req_addr[1:0])};
                wdata_q  <= req_wdata;
                err_q    <= acc_err;
            end
            if (state == WAIT && bus_rvalid) rdata_q <= load_result;
        end
    end

    next_load_extract u_extract (
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .word    (bus_rdata),
        .result  (load_result)
    );

    assign req_ready = (state == IDLE);
    assign bus_req   = (state == REQ);
    assign bus_we    = bus_req && we_q;
    assign bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be    = bus_req ? byte_enable(funct3_q, addr_q[1:0]) : '0;
    assign bus_wdata = bus_we ? store_repl(funct3_q, wdata_q) : '0;
    assign rsp_valid = (state == DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_next_lsu.sv
// Self-checking bench for next_lsu: scoreboard of expected responses, bench-driven bus.
module tb_next_lsu;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          bus_req, bus_gnt, bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] exp_last = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    next_lsu #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(off)));
        h = 16'(w >> (16 * int'(off[1])));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'($signed(h));
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        if (!exp_err && !we) exp_last = exp_rdata;
        sb.push_back({exp_err, exp_last});
        step;
        cyc = 1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_rsp(input string name, input int exp_cyc);
        rsp_t e;
        for (int i = 0; i < 12 && rsp_valid !== 1'b1; i++) step;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1 within budget", name, rsp_valid);
        end else begin
            n_checks++;
            if (cyc != exp_cyc) begin
                n_fail++;
                $display("FAIL %s_latency: rsp_valid in cycle %0d required %0d", name, cyc, exp_cyc);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s_unexpected: response with empty scoreboard, required none", name);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s_err: rsp_err=%b required %b", name, rsp_err, e.err);
                end
                n_checks++;
                if (rsp_rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL %s_rdata: rsp_rdata=%h required %h", name, rsp_rdata, e.rdata);
                end
            end
        end
        step;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_after: rsp_valid=%b req_ready=%b required 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input int gnt_dly, input logic exp_err, input logic [31:0] exp_rdata,
                              input logic [AW-1:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        accept(we, f3, addr, wdata, exp_err, exp_rdata);
        if (exp_err) begin
            n_checks++;
            if (bus_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_no_bus: bus_req=%b required 0", name, bus_req);
            end
            wait_rsp(name, 1);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                n_checks++;
                if (bus_req !== 1'b1 || bus_addr !== exp_addr || bus_be !== exp_be || bus_we !== we) begin
                    n_fail++;
                    $display("FAIL %s_bus: req=%b addr=%h be=%b we=%b required 1 %h %b %b",
                             name, bus_req, bus_addr, bus_be, bus_we, exp_addr, exp_be, we);
                end
                if (we) begin
                    n_checks++;
                    if (bus_wdata !== exp_wdata) begin
                        n_fail++;
                        $display("FAIL %s_wdata: bus_wdata=%h required %h", name, bus_wdata, exp_wdata);
                    end
                end
                if (i < gnt_dly) step;
            end
            bus_gnt = 1'b1;
            step;
            bus_gnt = 1'b0;
            if (!we) begin
                bus_rvalid = 1'b1; bus_rdata = rdata;
                step;
                bus_rvalid = 1'b0; bus_rdata = $urandom;
            end
            wait_rsp(name, we ? gnt_dly + 2 : gnt_dly + 3);
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
            bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== '0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rv=%b err=%b rd=%h req=%b we=%b addr=%h be=%b wd=%h required 1 0 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
        end
        rst = 1'b1;
        step;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_store_byte;
        run_access("sb", 1'b1, 3'b000, 32'h3, 32'h000000A5, '0, 0, 1'b0, '0, 16'h0000, 4'b1000, 32'hA5A5A5A5);
    endtask

    task automatic test_load_byte;
        run_access("lb", 1'b0, 3'b000, 32'h2, $urandom, 32'h12F03456, 0, 1'b0, 32'hFFFFFFF0, 16'h0000, 4'b0100, '0);
        run_access("lbu", 1'b0, 3'b100, 32'h2, $urandom, 32'h12F03456, 0, 1'b0, 32'h000000F0, 16'h0000, 4'b0100, '0);
    endtask

    task automatic test_half_stall;
        run_access("lh_stall", 1'b0, 3'b001, 32'h4, $urandom, 32'h00008001, 3, 1'b0, 32'hFFFF8001, 16'h0004, 4'b0011, '0);
    endtask

    task automatic test_word_misalign;
`ifdef NEXT_LSU_MISALIGN_TRAP_EN
        run_access("sw_mis", 1'b1, 3'b010, 32'h6, 32'hDEADBEEF, '0, 0, 1'b1, '0, '0, '0, '0);
`else
        run_access("sw_mis", 1'b1, 3'b010, 32'h6, 32'hDEADBEEF, '0, 0, 1'b0, '0, 16'h0004, 4'b1111, 32'hDEADBEEF);
`endif
    endtask

    task automatic test_invalid;
        run_access("inv111", 1'b0, 3'b111, 32'h10, '0, '0, 0, 1'b1, '0, '0, '0, '0);
        run_access("inv011", 1'b1, 3'b011, 32'h20, 32'h1234, '0, 0, 1'b1, '0, '0, '0, '0);
        run_access("inv110", 1'b0, 3'b110, 32'h24, '0, '0, 0, 1'b1, '0, '0, '0, '0);
        bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'h55555555;
        step;
        step;
        bus_rvalid = 1'b0; bus_gnt = 1'b0;
        n_checks++;
        if (rsp_rdata !== exp_last || rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_idle: rd=%h rv=%b req=%b ready=%b required %h 0 0 1",
                     rsp_rdata, rsp_valid, bus_req, req_ready, exp_last);
        end
    endtask

    task automatic test_reset_midflight;
        accept(1'b0, 3'b010, 32'h8, '0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || bus_be !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_in_req: bus_req=%b bus_be=%b required 0 0000", bus_req, bus_be);
        end
        step;
        rst = 1'b1;
        sb.delete();
        exp_last = '0;
        step;
        accept(1'b0, 3'b010, 32'h8, '0, 1'b0, 32'h0);
        bus_gnt = 1'b1;
        step;
        bus_gnt = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_in_wait: bus_req=%b rsp_valid=%b rsp_rdata=%h required 0 0 0", bus_req, rsp_valid, rsp_rdata);
        end
        bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
        step;
        bus_rvalid = 1'b0;
        rst = 1'b1;
        sb.delete();
        step;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_release: ready=%b rv=%b rd=%h required 1 0 0", req_ready, rsp_valid, rsp_rdata);
        end
        run_access("lw_after_rst", 1'b0, 3'b010, 32'h8, '0, 32'hCAFEBABE, 0, 1'b0, 32'hCAFEBABE, 16'h0008, 4'b1111, '0);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b010};
        logic        wes [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 24; i++) begin
            int          k;
            logic [2:0]  f3;
            logic        we;
            logic [1:0]  off;
            logic [31:0] addr, wd, rd, ewd;
            logic [3:0]  ebe;
            k   = $urandom_range(0, 7);
            f3  = f3s[k];
            we  = wes[k];
            off = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3 == 3'b010) off = 2'b00;
            addr = {$urandom, off};
            wd = $urandom;
            rd = $urandom;
            case (f3[1:0])
                2'b00:   begin ebe = 4'(1 << off);                   ewd = {4{wd[7:0]}}; end
                2'b01:   begin ebe = off[1] ? 4'b1100 : 4'b0011;     ewd = {2{wd[15:0]}}; end
                default: begin ebe = 4'b1111;                        ewd = wd; end
            endcase
            run_access("b2b", we, f3, addr, wd, rd, $urandom_range(0, 2), 1'b0,
                       load_model(f3, off, rd), {addr[AW-1:2], 2'b00}, ebe, ewd);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_store_byte;
        test_load_byte;
        test_half_stall;
        test_word_misalign;
        test_invalid;
        test_reset_midflight;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
